slave_out_port: RTL and testbench

- Slave-side serializer feeding master_in_port over the serial bus.
- Accepts parallel words from the slave core after a read request has been decoded.
- Shifts each word out LSB-first on one data line, using the slave_valid/master_ready handshake.
- Supports single reads and bursts of burst_num+1 words, matching master_in_port's word count.

---
 rtl/serial_bus_pkg.sv | 17 +
 rtl/piso_shift_reg.sv | 38 +++
 rtl/slave_out_port.sv | 180 ++++++++++++++++++
 tb/tb_slave_out_port.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial bus ports: FSM states, instruction codes
// and default word/burst widths.
package serial_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HANDSHAKE,
        SHIFT
    } state_e;

    localparam logic [1:0] READ = 2'b11;

    localparam int unsigned DEF_WORD_SIZE  = 8;
    localparam int unsigned DEF_BURST_SIZE = 12;

endpackage

// File: rtl/piso_shift_reg.sv
// LSB-first parallel-in serial-out register; dout is the current register LSB,
// and each shift moves the next bit down with zero fill from the top.
module piso_shift_reg
    import serial_bus_pkg::*;
#(
    parameter int unsigned WORD_SIZE = DEF_WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 shift,
    input  logic [WORD_SIZE-1:0] din,
    output logic                 dout
);

    logic [WORD_SIZE-1:0] sreg_q;
    logic [WORD_SIZE-1:0] sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (load) begin
            sreg_d = din;
        end else if (shift) begin
            sreg_d = {1'b0, sreg_q[WORD_SIZE-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign dout = sreg_q[0];

endmodule

// File: rtl/slave_out_port.sv
// Slave-side serializer: fetches words from the core and shifts them LSB-first
// to master_in_port. Optional handshake timeout via SLAVE_OUT_TIMEOUT_EN.
module slave_out_port
    import serial_bus_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = DEF_WORD_SIZE,
    parameter int unsigned BURST_SIZE = DEF_BURST_SIZE
`ifdef SLAVE_OUT_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT    = 1024
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BURST_SIZE-1:0] burst_num,
    input  logic [WORD_SIZE-1:0]  core_data,
    input  logic                  core_valid,
    output logic                  core_ready,
    input  logic                  master_ready,
    output logic                  tx_data,
    output logic                  slave_valid,
    output logic                  tx_complete
`ifdef SLAVE_OUT_TIMEOUT_EN
    ,
    output logic                  timeout_err
`endif
);

    localparam int unsigned      CNT_W    = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_SIZE - 1);

    state_e                state_q, state_d;
    logic [BURST_SIZE-1:0] burst_lim_q, burst_lim_d;
    logic [BURST_SIZE-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  core_ready_q, core_ready_d;
    logic                  slave_valid_q, slave_valid_d;
    logic                  tx_complete_q, tx_complete_d;

    logic                  sr_load;
    logic                  sr_shift;
    logic [WORD_SIZE-1:0]  sr_din;

`ifdef SLAVE_OUT_TIMEOUT_EN
    localparam int unsigned     WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_err_q, timeout_err_d;
`endif

    always_comb begin
        state_d       = state_q;
        burst_lim_d   = burst_lim_q;
        word_cnt_d    = word_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        core_ready_d  = core_ready_q;
        slave_valid_d = slave_valid_q;
        tx_complete_d = 1'b0;
        sr_load       = 1'b0;
        sr_shift      = 1'b0;
        sr_din        = core_data;
`ifdef SLAVE_OUT_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    burst_lim_d  = burst_num;
                    word_cnt_d   = '0;
                    core_ready_d = 1'b1;
                    state_d      = FETCH;
                end
            end

            FETCH: begin
                if (core_valid && core_ready_q) begin
                    sr_load       = 1'b1;
                    core_ready_d  = 1'b0;
                    slave_valid_d = 1'b1;
                    state_d       = HANDSHAKE;
                end
            end

            HANDSHAKE: begin
                if (slave_valid_q && master_ready) begin
                    sr_shift      = 1'b1;
                    slave_valid_d = 1'b0;
                    bit_cnt_d     = CNT_W'(1);
                    state_d       = SHIFT;
`ifdef SLAVE_OUT_TIMEOUT_EN
                    wait_cnt_d    = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Reload zeros so tx_data idles low after the abandoned word.
                    sr_load       = 1'b1;
                    sr_din        = '0;
                    slave_valid_d = 1'b0;
                    timeout_err_d = 1'b1;
                    wait_cnt_d    = '0;
                    state_d       = IDLE;
                end else begin
                    wait_cnt_d    = wait_cnt_q + 1'b1;
`endif
                end
            end

            SHIFT: begin
                // The final shift empties the register, leaving tx_data low.
                sr_shift = 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    if (word_cnt_q == burst_lim_q) begin
                        tx_complete_d = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        word_cnt_d   = word_cnt_q + 1'b1;
                        core_ready_d = 1'b1;
                        state_d      = FETCH;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            burst_lim_q   <= '0;
            word_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            core_ready_q  <= 1'b0;
            slave_valid_q <= 1'b0;
            tx_complete_q <= 1'b0;
`ifdef SLAVE_OUT_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            burst_lim_q   <= burst_lim_d;
            word_cnt_q    <= word_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            core_ready_q  <= core_ready_d;
            slave_valid_q <= slave_valid_d;
            tx_complete_q <= tx_complete_d;
`ifdef SLAVE_OUT_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    piso_shift_reg #(
        .WORD_SIZE(WORD_SIZE)
    ) u_piso (
        .clk  (clk),
        .reset(reset),
        .load (sr_load),
        .shift(sr_shift),
        .din  (sr_din),
        .dout (tx_data)
    );

    assign core_ready  = core_ready_q;
    assign slave_valid = slave_valid_q;
    assign tx_complete = tx_complete_q;
`ifdef SLAVE_OUT_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_slave_out_port.sv
// Bench for slave_out_port: randomized traffic against a transaction-level model,
// plus directed transfers with literal expectations.
module tb_slave_out_port;

    localparam int unsigned W = 8;
    localparam int unsigned B = 12;
`ifdef SLAVE_OUT_TIMEOUT_EN
    localparam int unsigned TO = 16;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [B-1:0] burst_num = '0;
    logic [W-1:0] core_data = '0;
    logic         core_valid = 1'b0;
    logic         master_ready = 1'b0;
    logic         core_ready;
    logic         tx_data;
    logic         slave_valid;
    logic         tx_complete;
    logic         dut_err;

    always #5 clk = ~clk;

`ifdef SLAVE_OUT_TIMEOUT_EN
    logic timeout_err;
    assign dut_err = timeout_err;
`else
    assign dut_err = 1'b0;
`endif

    slave_out_port #(
        .WORD_SIZE (W),
        .BURST_SIZE(B)
`ifdef SLAVE_OUT_TIMEOUT_EN
        ,
        .TIMEOUT   (TO)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .burst_num   (burst_num),
        .core_data   (core_data),
        .core_valid  (core_valid),
        .core_ready  (core_ready),
        .master_ready(master_ready),
        .tx_data     (tx_data),
        .slave_valid (slave_valid),
        .tx_complete (tx_complete)
`ifdef SLAVE_OUT_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    int errors = 0;
    int checks = 0;
    int mr_pct = 100;
    int stall_pct = 0;

    logic [W-1:0] feed_q[$];
    logic [W-1:0] acc_q[$];
    logic [W-1:0] rx_q[$];
    int hs_cnt = 0;
    int done_cnt = 0;
    int acc_cnt = 0;

    // Transaction-level model: what the port is doing, not how.
    bit           m_fetch = 1'b0;
    bit           m_offer = 1'b0;
    bit           m_done = 1'b0;
    bit           m_err = 1'b0;
    int           m_bit = 0;
    int           m_left = 0;
    int           m_wait = 0;
    logic [W-1:0] m_word = '0;

    int           col_idx = 0;
    logic [W-1:0] col_word = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic       exp_tx;
        logic [4:0] got_v;
        logic [4:0] exp_v;

        exp_tx = (m_offer || m_bit > 0) ? m_word[m_bit] : 1'b0;
        got_v  = {core_ready, slave_valid, tx_data, tx_complete, dut_err};
        exp_v  = {m_fetch, m_offer, exp_tx, m_done, m_err};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL cycle rdy/sv/tx/done/err: got %b expected %b (t=%0t)", got_v, exp_v, $time);
        end

        if (reset) begin
            if (slave_valid && master_ready) hs_cnt++;
            if (tx_complete) done_cnt++;
            if (core_ready && core_valid) acc_cnt++;
        end

        // Master-side view: bit 0 taken on the handshake edge, then one bit per edge.
        if (!reset) begin
            col_idx = 0;
        end else if (col_idx > 0) begin
            col_word[col_idx] = tx_data;
            col_idx++;
            if (col_idx == W) begin
                rx_q.push_back(col_word);
                col_idx = 0;
            end
        end else if (slave_valid && master_ready) begin
            col_word    = '0;
            col_word[0] = tx_data;
            col_idx     = 1;
        end

        // Advance the model over the coming edge using the inputs it will sample.
        if (!reset) begin
            m_fetch = 1'b0;
            m_offer = 1'b0;
            m_done  = 1'b0;
            m_err   = 1'b0;
            m_bit   = 0;
            m_left  = 0;
            m_wait  = 0;
        end else begin
            m_done = 1'b0;
            if (m_bit > 0) begin
                if (m_bit == W - 1) begin
                    m_bit = 0;
                    if (m_left == 0) begin
                        m_done = 1'b1;
                    end else begin
                        m_left--;
                        m_fetch = 1'b1;
                    end
                end else begin
                    m_bit++;
                end
            end else if (m_offer) begin
                if (master_ready) begin
                    m_offer = 1'b0;
                    m_bit   = 1;
`ifdef SLAVE_OUT_TIMEOUT_EN
                end else if (m_wait == TO - 1) begin
                    m_offer = 1'b0;
                    m_err   = 1'b1;
                end else begin
                    m_wait++;
`endif
                end
            end else if (m_fetch) begin
                if (core_valid) begin
                    m_word  = core_data;
                    m_fetch = 1'b0;
                    m_offer = 1'b1;
                    m_wait  = 0;
                end
            end else if (start) begin
                m_fetch = 1'b1;
                m_left  = int'(burst_num);
            end
        end
    end

    task automatic step();
        bit acc;
        acc = reset && core_ready && core_valid;
        @(posedge clk);
        #1;
        if (acc) acc_q.push_back(feed_q.pop_front());
        start        = 1'b0;
        master_ready = ($urandom_range(0, 99) < mr_pct);
        if (feed_q.size() > 0 && $urandom_range(0, 99) >= stall_pct) begin
            core_valid = 1'b1;
            core_data  = feed_q[0];
        end else begin
            core_valid = 1'b0;
            core_data  = W'($urandom);
        end
    endtask

    task automatic start_xfer(input logic [B-1:0] bn);
        rx_q.delete();
        acc_q.delete();
        start     = 1'b1;
        burst_num = bn;
        step();
    endtask

    task automatic wait_done(input string tag, input int budget, input bit poke);
        int d0;
        bit ok;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (poke && i == 4) begin
                start     = 1'b1;
                burst_num = B'($urandom);
            end
            step();
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_completed"}, ok, 1'b1);
    endtask

    task automatic finish_xfer(input string tag, input int n);
        step();
        step();
        check({tag, "_rx_words"}, rx_q.size(), n);
        check({tag, "_acc_words"}, acc_q.size(), n);
        for (int i = 0; i < rx_q.size() && i < acc_q.size(); i++) begin
            check({tag, "_word"}, rx_q[i], acc_q[i]);
        end
    endtask

    initial begin
        int hs0;
        int d0;
        int a0;
        bit seen;
        int n;

        reset = 1'b0;
        repeat (3) step();
        check("reset_state", {core_ready, slave_valid, tx_data, tx_complete, dut_err}, 5'b0);
        reset = 1'b1;
        step();

        // Single word A5: bits 1,0,1,0,0,1,0,1 on the wire.
        feed_q = {8'hA5};
        hs0 = hs_cnt; d0 = done_cnt;
        start_xfer('0);
        wait_done("single", 60, 1'b0);
        finish_xfer("single", 1);
        check("single_a5", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'hA5);
        check("single_hs", hs_cnt - hs0, 1);
        check("single_done", done_cnt - d0, 1);

        // Three-word burst with a stray start mid-transfer.
        feed_q = {8'h01, 8'h80, 8'hFF};
        hs0 = hs_cnt; d0 = done_cnt; a0 = acc_cnt;
        start_xfer(B'(2));
        wait_done("burst", 120, 1'b1);
        finish_xfer("burst", 3);
        check("burst_w0", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h01);
        check("burst_w1", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'h80);
        check("burst_w2", (rx_q.size() > 2) ? rx_q[2] : 8'hxx, 8'hFF);
        check("burst_hs", hs_cnt - hs0, 3);
        check("burst_acc", acc_cnt - a0, 3);
        check("burst_done", done_cnt - d0, 1);

        // Master holds ready low for 5 cycles after slave_valid rises.
        mr_pct = 0;
        feed_q = {8'h3C};
        start_xfer('0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (slave_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("stall_sv_rise", seen, 1'b1);
        repeat (5) step();
        check("stall_sv_held", slave_valid, 1'b1);
        check("stall_tx_bit0", tx_data, 1'b0);
        mr_pct = 100;
        wait_done("stall", 60, 1'b0);
        finish_xfer("stall", 1);
        check("stall_word", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h3C);

        // Core starves between burst words.
        feed_q = {8'h5A};
        start_xfer(B'(1));
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (acc_q.size() == 1) begin
                seen = 1'b1;
                break;
            end
        end
        check("starve_first_acc", seen, 1'b1);
        repeat (18) step();
        check("starve_sv_low", slave_valid, 1'b0);
        check("starve_fetch", core_ready, 1'b1);
        feed_q.push_back(8'hC3);
        wait_done("starve", 60, 1'b0);
        finish_xfer("starve", 2);
        check("starve_w1", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'hC3);

        // Reset while bit 3 is on the line.
        feed_q = {8'hF0};
        hs0 = hs_cnt;
        start_xfer('0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (hs_cnt != hs0) begin
                seen = 1'b1;
                break;
            end
        end
        check("rstmid_handshake", seen, 1'b1);
        step();
        step();
        d0 = done_cnt;
        reset = 1'b0;
        step();
        check("rstmid_outputs", {core_ready, slave_valid, tx_data, tx_complete, dut_err}, 5'b0);
        reset = 1'b1;
        feed_q.delete();
        repeat (12) step();
        check("rstmid_no_done", done_cnt - d0, 0);
        check("rstmid_no_word", rx_q.size(), 0);
        feed_q = {8'h96};
        start_xfer('0);
        wait_done("after_rst", 60, 1'b0);
        finish_xfer("after_rst", 1);
        check("after_rst_word", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h96);

        // Randomized traffic.
        mr_pct = 60;
        stall_pct = 30;
        for (int t = 0; t < 15; t++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) feed_q.push_back(W'($urandom));
            start_xfer(B'(n - 1));
            wait_done("rand", 600, t[0]);
            finish_xfer("rand", n);
        end

        // All-ones burst_num: 2^B words, single completion.
        mr_pct = 100;
        stall_pct = 0;
        for (int i = 0; i < (1 << B); i++) feed_q.push_back(W'($urandom));
        d0 = done_cnt; hs0 = hs_cnt;
        start_xfer('1);
        wait_done("maxburst", 10 * (1 << B), 1'b0);
        finish_xfer("maxburst", 1 << B);
        check("maxburst_hs", hs_cnt - hs0, 1 << B);
        check("maxburst_done", done_cnt - d0, 1);

`ifdef SLAVE_OUT_TIMEOUT_EN
        // Master never answers: slave_valid drops after TO cycles, sticky error.
        mr_pct = 0;
        feed_q = {8'h77};
        d0 = done_cnt;
        start_xfer('0);
        repeat (25) step();
        check("timeout_err_set", dut_err, 1'b1);
        check("timeout_sv_low", slave_valid, 1'b0);
        check("timeout_no_done", done_cnt - d0, 0);
        repeat (5) step();
        check("timeout_err_sticky", dut_err, 1'b1);
        reset = 1'b0;
        step();
        check("timeout_err_clear", dut_err, 1'b0);
        reset = 1'b1;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
